hazard_ctrl: RTL

Pipeline hazard controller for the 8-bit five-stage processor. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and decides each cycle whether the front end advances, stalls, flushes or freezes. It also generates the EX-stage operand forwarding selects. It keeps a 3-entry destination scoreboard that mirrors the EX, MEM and WB stages and a saturating stall counter.

---
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: per-cycle RUN/STALL/FLUSH/FREEZE decision, destination scoreboard and EX forwarding selects.
// Define HAZARD_FWD_EN to enable EX operand forwarding; otherwise dependents stall until WB.
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] idRs,
    input  logic [2:0] idRt,
    input  logic       idUsesRs,
    input  logic       idUsesRt,
    input  logic [2:0] idRd,
    input  logic       idWritesReg,
    input  logic       idIsLoad,
    input  logic       exBranchTaken,
    input  logic       exJump,
    input  logic       memBusy,
    output logic       pcWrite,
    output logic       ifIdWrite,
    output logic       idExWrite,
    output logic       idExBubble,
    output logic       ifIdFlush,
    output logic [1:0] fwdA,
    output logic [1:0] fwdB,
    output logic [1:0] state,
    output logic [7:0] stallCount
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        STALL  = 2'b01,
        FLUSH  = 2'b10,
        FREEZE = 2'b11
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] rd;
        logic       isLoad;
    } sb_t;

    sb_t        sbEx, sbMem, sbWb;
    logic [2:0] exRs, exRt;
    logic [7:0] cnt;
    state_t     cur;
    logic       hazard;

    function automatic logic hit(input logic used, input logic [2:0] r, input sb_t e);
        return used && e.valid && (e.rd == r);
    endfunction

`ifdef HAZARD_FWD_EN
    // Only a load in EX cannot be bypassed in time.
    assign hazard = sbEx.isLoad &&
                    (hit(idUsesRs, idRs, sbEx) || hit(idUsesRt, idRt, sbEx));

    always_comb begin
        fwdA = 2'b00;
        fwdB = 2'b00;
        if (hit(1'b1, exRs, sbMem))
            fwdA = 2'b01;
        else if (hit(1'b1, exRs, sbWb))
            fwdA = 2'b10;
        if (hit(1'b1, exRt, sbMem))
            fwdB = 2'b01;
        else if (hit(1'b1, exRt, sbWb))
            fwdB = 2'b10;
    end
`else
    // Register file writes early in the cycle, so a WB producer is already visible.
    assign hazard = hit(idUsesRs, idRs, sbEx)  || hit(idUsesRt, idRt, sbEx) ||
                    hit(idUsesRs, idRs, sbMem) || hit(idUsesRt, idRt, sbMem);
    assign fwdA   = 2'b00;
    assign fwdB   = 2'b00;
`endif

    always_comb begin
        cur        = RUN;
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        idExWrite  = 1'b1;
        idExBubble = 1'b0;
        ifIdFlush  = 1'b0;
        if (rst) begin
            cur = RUN;
        end else if (memBusy) begin
            cur       = FREEZE;
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExWrite = 1'b0;
        end else if (exBranchTaken || exJump) begin
            cur        = FLUSH;
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
        end else if (hazard) begin
            cur        = STALL;
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
        end
    end

    assign state      = cur;
    assign stallCount = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbEx  <= '0;
            sbMem <= '0;
            sbWb  <= '0;
            exRs  <= 3'd0;
            exRt  <= 3'd0;
            cnt   <= 8'd0;
        end else begin
            if (cur != FREEZE) begin
                sbWb  <= sbMem;
                sbMem <= sbEx;
                if (idExBubble) begin
                    sbEx <= '0;
                    exRs <= 3'd0;
                    exRt <= 3'd0;
                end else begin
                    sbEx <= '{valid: idWritesReg, rd: idRd, isLoad: idIsLoad};
                    exRs <= idRs;
                    exRt <= idRt;
                end
            end
            if (cur != RUN && cnt != 8'hFF)
                cnt <= cnt + 8'd1;
        end
    end

endmodule
